serial_fifo_bridge: RTL and testbench
=====================================

Name: serial_fifo_bridge

Overview:
- Buffers serial I/O bytes between the processor's data-memory serial ports and the external byte-serial link (UART core).
- RX path: external bytes go into the RX FIFO and are presented to the processor as serial_in / serial_valid_in.
- TX path: processor writes (serial_out / serial_wren_out) go into the TX FIFO, which drains to the link over a valid/ready output register.
- Sits directly beside the processor; its processor-side ports connect one-to-one to the processor's serial ports.

Parameters:
- DEPTH, 8, entries per FIFO; must be a power of 2, at least 2.
- CW, $clog2(DEPTH)+1, width of the occupancy counts.

Ports:
- clock  in  1  single clock for the whole block.
- reset  in  1  asynchronous, active-low reset.
- serial_in  out  8  RX FIFO head byte to the processor (show-ahead).
- serial_valid_in  out  1  RX FIFO non-empty.
- serial_ready_in  out  1  TX FIFO not full.
- serial_out  in  8  byte written by the processor.
- serial_rden_out  in  1  processor consumes the RX head byte.
- serial_wren_out  in  1  processor writes serial_out.
- ext_rx_data  in  8  received byte from the link.
- ext_rx_strobe  in  1  one-cycle strobe; the link has no backpressure.
- ext_tx_data  out  8  byte to transmit.
- ext_tx_valid  out  1  ext_tx_data is valid.
- ext_tx_ready  in  1  link accepts the byte.
- rx_overrun  out  1  sticky: an RX byte was dropped because the FIFO was full.
- tx_overflow  out  1  sticky: a TX write was dropped because the FIFO was full.
- flag_clr  in  1  synchronous clear of both sticky flags.
- rx_count  out  CW  RX FIFO occupancy.
- tx_count  out  CW  TX FIFO occupancy.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low.
- Reset values (reset low, applied immediately):
  - FIFOs empty; counts 0.
  - serial_valid_in=0, serial_in=0, serial_ready_in=1.
  - ext_tx_valid=0, ext_tx_data=0.
  - Both sticky flags 0.
  - Asserting reset mid-transfer discards all buffered bytes and the pending output byte.
- RX push: at a clock edge with ext_rx_strobe=1.
  - Not full: byte written.
  - Full: byte dropped and rx_overrun set.
  - Exception: full with serial_rden_out=1 in the same cycle accepts the byte; count unchanged.
- RX pop: at a clock edge with serial_rden_out=1 and rx_count>0.
  - serial_rden_out while empty: ignored, no flag.
  - Each cycle rden is held pops one byte.
  - serial_in and serial_valid_in are combinational from read pointer and count; a byte strobed at edge N is visible right after edge N.
- TX push: at a clock edge with serial_wren_out=1.
  - Not full: byte written.
  - Full: byte dropped and tx_overflow set.
  - Simultaneous push and pop while full is accepted.
- TX output register, state machine IDLE/HOLD:
  - IDLE and tx_count>0: load the head into ext_tx_data, pop it, set ext_tx_valid, go to HOLD.
  - HOLD and ext_tx_ready=1: if tx_count>0, reload the next byte in the same edge (back-to-back, one byte per cycle); otherwise clear valid and go to IDLE.
  - HOLD and ext_tx_ready=0: ext_tx_data and ext_tx_valid held stable.
  - Latency: a byte written at edge N is first valid after edge N+1.
- Pointers: log2(DEPTH) bits each, natural wrap. Counts saturate by construction, 0..DEPTH.
- Sticky flags: flag_clr clears both flags. A drop in the same cycle as flag_clr wins, so the flag stays set.
- Byte order is strictly preserved on both paths.

Optional Feature:
- Macro: SERIAL_BRIDGE_LOOPBACK_EN.
- Defined:
  - Each byte the output register would present is pushed into the RX FIFO instead. The handoff is accepted when the RX FIFO is not full, or when it is full and popped in the same cycle; otherwise the byte waits in TX.
  - ext_tx_valid is held 0; ext_rx_strobe is ignored.
  - If an internal push and a processor pop hit the same edge, both occur.
- Undefined: normal behaviour as above; no loopback logic is synthesized.

Decomposition:
- Shared package serial_bridge_pkg:
  - SERIAL_BYTE_W = 8.
  - DEFAULT_SERIAL_DEPTH = 8.
  - TX state enum: TX_IDLE, TX_HOLD.
- One sub-module, byte_fifo. Two instances (RX and TX).
  - Parameter: DEPTH.
  - Ports: push/pop, data in, head out, count, full, empty.
  - Simultaneous push/pop while full is legal.

Test Plan:
- Reset, then strobe 8'h48 at edge 1 -> serial_valid_in=1 and serial_in=8'h48 after edge 1; serial_rden_out for one cycle -> valid=0, rx_count=0.
- Strobe 9 bytes 8'h01..8'h09 with DEPTH=8 and no pops -> rx_count=8, rx_overrun=1, bytes 8'h01..8'h08 read in order; flag_clr -> rx_overrun=0.
- Processor writes 8'h41, 8'h42, 8'h43 in consecutive cycles with ext_tx_ready=1 -> ext_tx_valid from edge after first write, data 41, 42, 43 on consecutive cycles, then valid=0.
- ext_tx_ready=0 for 5 cycles with 8'h55 pending -> ext_tx_data=8'h55 and ext_tx_valid=1 stable; tx_count reflects the remaining bytes; ready=1 releases the byte.
- TX FIFO full (8 entries plus the held output byte) with a write and an external accept in the same cycle -> no overflow flag; a further write with no accept -> tx_overflow=1 and the byte is lost.
- Drive reset low mid-burst with 3 bytes in each FIFO -> all counts 0, ext_tx_valid=0, serial_ready_in=1 immediately, asynchronously.

Source files
------------

// File: rtl/serial_bridge_pkg.sv
// Shared types and constants for the serial FIFO bridge.
// Optional feature macro used by the top: SERIAL_BRIDGE_LOOPBACK_EN.
package serial_bridge_pkg;

    localparam int unsigned SERIAL_BYTE_W        = 8;
    localparam int unsigned DEFAULT_SERIAL_DEPTH = 8;

    typedef enum logic {
        TX_IDLE = 1'b0,
        TX_HOLD = 1'b1
    } tx_state_e;

endpackage

// File: rtl/byte_fifo.sv
// Show-ahead byte FIFO; a push while full is accepted when a pop lands in the same cycle.
module byte_fifo
    import serial_bridge_pkg::*;
#(
    parameter  int unsigned DEPTH = DEFAULT_SERIAL_DEPTH,
    localparam int unsigned AW    = $clog2(DEPTH),
    localparam int unsigned CW    = AW + 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic [SERIAL_BYTE_W-1:0] data_i,
    output logic [SERIAL_BYTE_W-1:0] head_o,
    output logic [CW-1:0]            count_o,
    output logic                     full_o,
    output logic                     empty_o
);

    logic [SERIAL_BYTE_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]            wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]            count_q;
    logic                     do_push, do_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CW'(DEPTH));
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);
    assign count_o = count_q;
    // Head is forced to zero when empty so reset presents a clean byte.
    assign head_o  = empty_o ? '0 : mem_q[rd_ptr_q];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= data_i;
    end

endmodule

// File: rtl/serial_fifo_bridge.sv
// RX/TX byte buffering between the processor serial ports and the UART link.
// Define SERIAL_BRIDGE_LOOPBACK_EN to route TX bytes back into the RX FIFO.
module serial_fifo_bridge
    import serial_bridge_pkg::*;
#(
    parameter int unsigned DEPTH = DEFAULT_SERIAL_DEPTH,
    parameter int unsigned CW    = $clog2(DEPTH) + 1
) (
    input  logic                     clock,
    input  logic                     reset,
    output logic [SERIAL_BYTE_W-1:0] serial_in,
    output logic                     serial_valid_in,
    output logic                     serial_ready_in,
    input  logic [SERIAL_BYTE_W-1:0] serial_out,
    input  logic                     serial_rden_out,
    input  logic                     serial_wren_out,
    input  logic [SERIAL_BYTE_W-1:0] ext_rx_data,
    input  logic                     ext_rx_strobe,
    output logic [SERIAL_BYTE_W-1:0] ext_tx_data,
    output logic                     ext_tx_valid,
    input  logic                     ext_tx_ready,
    output logic                     rx_overrun,
    output logic                     tx_overflow,
    input  logic                     flag_clr,
    output logic [CW-1:0]            rx_count,
    output logic [CW-1:0]            tx_count
);

    logic                     rx_push, rx_full, rx_empty;
    logic [SERIAL_BYTE_W-1:0] rx_wdata;
    logic                     tx_pop, tx_full, tx_empty;
    logic [SERIAL_BYTE_W-1:0] tx_head;

    tx_state_e                state_q, state_d;
    logic [SERIAL_BYTE_W-1:0] tx_data_q, tx_data_d;
    logic                     tx_valid_q, tx_valid_d;
    logic                     rx_overrun_q, rx_overrun_d;
    logic                     tx_overflow_q, tx_overflow_d;

    byte_fifo #(.DEPTH(DEPTH)) u_rx_fifo (
        .clk     (clock),
        .rst_n   (reset),
        .push_i  (rx_push),
        .pop_i   (serial_rden_out),
        .data_i  (rx_wdata),
        .head_o  (serial_in),
        .count_o (rx_count),
        .full_o  (rx_full),
        .empty_o (rx_empty)
    );

    byte_fifo #(.DEPTH(DEPTH)) u_tx_fifo (
        .clk     (clock),
        .rst_n   (reset),
        .push_i  (serial_wren_out),
        .pop_i   (tx_pop),
        .data_i  (serial_out),
        .head_o  (tx_head),
        .count_o (tx_count),
        .full_o  (tx_full),
        .empty_o (tx_empty)
    );

    assign serial_valid_in = !rx_empty;
    assign serial_ready_in = !tx_full;

`ifdef SERIAL_BRIDGE_LOOPBACK_EN
    logic unused_lb;
    assign unused_lb = ^{ext_rx_data, ext_rx_strobe, ext_tx_ready, state_q, tx_data_q, tx_valid_q};

    // A full RX FIFO is non-empty, so a pending rden frees a slot this cycle.
    always_comb begin
        state_d    = TX_IDLE;
        tx_data_d  = '0;
        tx_valid_d = 1'b0;
        tx_pop     = !tx_empty && (!rx_full || serial_rden_out);
        rx_push    = tx_pop;
        rx_wdata   = tx_head;
    end
`else
    // Output register: load on idle, reload back-to-back on accept, hold otherwise.
    always_comb begin
        state_d    = state_q;
        tx_data_d  = tx_data_q;
        tx_valid_d = tx_valid_q;
        tx_pop     = 1'b0;
        rx_push    = ext_rx_strobe;
        rx_wdata   = ext_rx_data;
        case (state_q)
            TX_IDLE: begin
                if (!tx_empty) begin
                    tx_data_d  = tx_head;
                    tx_valid_d = 1'b1;
                    tx_pop     = 1'b1;
                    state_d    = TX_HOLD;
                end
            end
            TX_HOLD: begin
                if (ext_tx_ready) begin
                    if (!tx_empty) begin
                        tx_data_d = tx_head;
                        tx_pop    = 1'b1;
                    end else begin
                        tx_valid_d = 1'b0;
                        state_d    = TX_IDLE;
                    end
                end
            end
            default: state_d = TX_IDLE;
        endcase
    end
`endif

    // A drop coinciding with flag_clr keeps the flag set.
    always_comb begin
        rx_overrun_d  = (flag_clr ? 1'b0 : rx_overrun_q)
                        | (rx_push && rx_full && !serial_rden_out);
        tx_overflow_d = (flag_clr ? 1'b0 : tx_overflow_q)
                        | (serial_wren_out && tx_full && !tx_pop);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q       <= TX_IDLE;
            tx_data_q     <= '0;
            tx_valid_q    <= 1'b0;
            rx_overrun_q  <= 1'b0;
            tx_overflow_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            tx_data_q     <= tx_data_d;
            tx_valid_q    <= tx_valid_d;
            rx_overrun_q  <= rx_overrun_d;
            tx_overflow_q <= tx_overflow_d;
        end
    end

    assign ext_tx_data  = tx_data_q;
    assign ext_tx_valid = tx_valid_q;
    assign rx_overrun   = rx_overrun_q;
    assign tx_overflow  = tx_overflow_q;

endmodule

// File: tb/tb_serial_fifo_bridge.sv
// Scoreboard bench for serial_fifo_bridge: expected bytes queued at stimulus, checked by a monitor.
module tb_serial_fifo_bridge;

    localparam int unsigned DEPTH = 8;
    localparam int unsigned CW    = $clog2(DEPTH) + 1;

    logic          clock = 1'b0;
    logic          reset;
    logic [7:0]    serial_in;
    logic          serial_valid_in, serial_ready_in;
    logic [7:0]    serial_out;
    logic          serial_rden_out, serial_wren_out;
    logic [7:0]    ext_rx_data;
    logic          ext_rx_strobe;
    logic [7:0]    ext_tx_data;
    logic          ext_tx_valid, ext_tx_ready;
    logic          rx_overrun, tx_overflow, flag_clr;
    logic [CW-1:0] rx_count, tx_count;

    int n_checks = 0;
    int n_fail   = 0;
    logic [7:0] rx_q[$];
    logic [7:0] tx_q[$];

    serial_fifo_bridge #(.DEPTH(DEPTH)) dut (
        .clock           (clock),
        .reset           (reset),
        .serial_in       (serial_in),
        .serial_valid_in (serial_valid_in),
        .serial_ready_in (serial_ready_in),
        .serial_out      (serial_out),
        .serial_rden_out (serial_rden_out),
        .serial_wren_out (serial_wren_out),
        .ext_rx_data     (ext_rx_data),
        .ext_rx_strobe   (ext_rx_strobe),
        .ext_tx_data     (ext_tx_data),
        .ext_tx_valid    (ext_tx_valid),
        .ext_tx_ready    (ext_tx_ready),
        .rx_overrun      (rx_overrun),
        .tx_overflow     (tx_overflow),
        .flag_clr        (flag_clr),
        .rx_count        (rx_count),
        .tx_count        (tx_count)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Inputs only change just after posedge, so negedge sees the handshake the next edge will take.
    always @(negedge clock) begin : monitor
        logic [7:0] exp_b;
        if (reset) begin
            if (ext_tx_valid && ext_tx_ready) begin
                if (tx_q.size() == 0) begin
                    n_checks++; n_fail++;
                    $display("FAIL tx_unexpected: got %0h, none expected", ext_tx_data);
                end else begin
                    exp_b = tx_q.pop_front();
                    chk("tx_byte", 32'(ext_tx_data), 32'(exp_b));
                end
            end
            if (serial_rden_out && serial_valid_in) begin
                if (rx_q.size() == 0) begin
                    n_checks++; n_fail++;
                    $display("FAIL rx_unexpected: got %0h, none expected", serial_in);
                end else begin
                    exp_b = rx_q.pop_front();
                    chk("rx_byte", 32'(serial_in), 32'(exp_b));
                end
            end
        end
    end

    initial begin
        reset = 1'b0;
        serial_out = '0; serial_rden_out = 1'b0; serial_wren_out = 1'b0;
        ext_rx_data = '0; ext_rx_strobe = 1'b0; ext_tx_ready = 1'b0; flag_clr = 1'b0;

        #3;
        chk("rst_valid_in", 32'(serial_valid_in), 32'd0);
        chk("rst_serial_in", 32'(serial_in), 32'd0);
        chk("rst_ready_in", 32'(serial_ready_in), 32'd1);
        chk("rst_tx_valid", 32'(ext_tx_valid), 32'd0);
        chk("rst_tx_data", 32'(ext_tx_data), 32'd0);
        chk("rst_counts", 32'({rx_count, tx_count}), 32'd0);
        chk("rst_flags", 32'({rx_overrun, tx_overflow}), 32'd0);
        #9 reset = 1'b1;
        tick();

        // Single RX byte, show-ahead right after the strobe edge
        ext_rx_data = 8'h48; ext_rx_strobe = 1'b1; rx_q.push_back(8'h48);
        tick();
        ext_rx_strobe = 1'b0;
        chk("rx1_valid", 32'(serial_valid_in), 32'd1);
        chk("rx1_data", 32'(serial_in), 32'h48);
        serial_rden_out = 1'b1;
        tick();
        serial_rden_out = 1'b0;
        chk("rx1_valid_after_pop", 32'(serial_valid_in), 32'd0);
        chk("rx1_count_after_pop", 32'(rx_count), 32'd0);

        // Rden while empty is ignored
        serial_rden_out = 1'b1;
        tick();
        serial_rden_out = 1'b0;
        chk("rx_empty_pop_count", 32'(rx_count), 32'd0);
        chk("rx_empty_pop_flag", 32'(rx_overrun), 32'd0);

        // RX overrun: 9 strobes into 8 entries
        for (int i = 1; i <= 9; i++) begin
            ext_rx_data = 8'(i); ext_rx_strobe = 1'b1;
            if (i <= 8) rx_q.push_back(8'(i));
            tick();
        end
        ext_rx_strobe = 1'b0;
        chk("rx_full_count", 32'(rx_count), 32'd8);
        chk("rx_overrun_set", 32'(rx_overrun), 32'd1);
        chk("rx_full_head", 32'(serial_in), 32'h01);
        serial_rden_out = 1'b1;
        for (int i = 0; i < 8; i++) tick();
        serial_rden_out = 1'b0;
        chk("rx_drained_count", 32'(rx_count), 32'd0);
        chk("rx_overrun_sticky", 32'(rx_overrun), 32'd1);
        flag_clr = 1'b1;
        tick();
        flag_clr = 1'b0;
        chk("rx_overrun_clr", 32'(rx_overrun), 32'd0);

        // TX back-to-back with ready high
        ext_tx_ready = 1'b1;
        serial_wren_out = 1'b1; serial_out = 8'h41; tx_q.push_back(8'h41);
        tick();
        chk("tx_latency_not_yet", 32'(ext_tx_valid), 32'd0);
        serial_out = 8'h42; tx_q.push_back(8'h42);
        tick();
        chk("tx_first_valid", 32'(ext_tx_valid), 32'd1);
        chk("tx_first_data", 32'(ext_tx_data), 32'h41);
        serial_out = 8'h43; tx_q.push_back(8'h43);
        tick();
        serial_wren_out = 1'b0;
        chk("tx_second_data", 32'(ext_tx_data), 32'h42);
        tick();
        chk("tx_third_data", 32'(ext_tx_data), 32'h43);
        tick();
        chk("tx_idle_after_burst", 32'(ext_tx_valid), 32'd0);

        // Backpressure holds the output register stable
        ext_tx_ready = 1'b0;
        serial_wren_out = 1'b1; serial_out = 8'h55; tx_q.push_back(8'h55);
        tick();
        serial_out = 8'h66; tx_q.push_back(8'h66);
        tick();
        serial_wren_out = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk("hold_data", 32'(ext_tx_data), 32'h55);
            chk("hold_valid", 32'(ext_tx_valid), 32'd1);
            chk("hold_tx_count", 32'(tx_count), 32'd1);
            tick();
        end
        ext_tx_ready = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        chk("hold_released", 32'(ext_tx_valid), 32'd0);

        // TX full: write+accept accepted, write without accept dropped
        ext_tx_ready = 1'b0;
        serial_wren_out = 1'b1;
        for (int i = 0; i < 9; i++) begin
            serial_out = 8'hA0 + 8'(i); tx_q.push_back(8'hA0 + 8'(i));
            tick();
        end
        chk("tx_full_count", 32'(tx_count), 32'd8);
        chk("tx_full_ready_in", 32'(serial_ready_in), 32'd0);
        chk("tx_full_out_data", 32'(ext_tx_data), 32'hA0);
        serial_out = 8'hA9; tx_q.push_back(8'hA9); ext_tx_ready = 1'b1;
        tick();
        chk("tx_push_pop_full_flag", 32'(tx_overflow), 32'd0);
        chk("tx_push_pop_full_count", 32'(tx_count), 32'd8);
        ext_tx_ready = 1'b0; serial_out = 8'hAA;
        tick();
        serial_wren_out = 1'b0;
        chk("tx_overflow_set", 32'(tx_overflow), 32'd1);
        chk("tx_overflow_count", 32'(tx_count), 32'd8);
        ext_tx_ready = 1'b1;
        for (int i = 0; i < 12; i++) tick();
        chk("tx_drained_valid", 32'(ext_tx_valid), 32'd0);
        chk("tx_overflow_sticky", 32'(tx_overflow), 32'd1);
        flag_clr = 1'b1;
        tick();
        flag_clr = 1'b0;
        chk("tx_overflow_clr", 32'(tx_overflow), 32'd0);

        // Asynchronous reset mid-burst discards everything
        ext_tx_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            ext_rx_strobe = (i < 3); ext_rx_data = 8'hC0 + 8'(i);
            serial_wren_out = 1'b1; serial_out = 8'hD0 + 8'(i);
            tick();
        end
        ext_rx_strobe = 1'b0; serial_wren_out = 1'b0;
        chk("pre_rst_rx_count", 32'(rx_count), 32'd3);
        chk("pre_rst_tx_count", 32'(tx_count), 32'd3);
        chk("pre_rst_tx_valid", 32'(ext_tx_valid), 32'd1);
        #2 reset = 1'b0;
        #1;
        chk("arst_counts", 32'({rx_count, tx_count}), 32'd0);
        chk("arst_tx_valid", 32'(ext_tx_valid), 32'd0);
        chk("arst_ready_in", 32'(serial_ready_in), 32'd1);
        chk("arst_valid_in", 32'(serial_valid_in), 32'd0);
        tick();
        reset = 1'b1;
        tick();

        chk("rx_scoreboard_empty", 32'(rx_q.size()), 32'd0);
        chk("tx_scoreboard_empty", 32'(tx_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
